// File: rtl/dcmi_out_fifo_pkg.sv
// Shared constants for the DCMI output buffer: default word width, default
// FIFO depth and the bit positions of the frame tags in a packed FIFO entry.
package dcmi_out_fifo_pkg;

  localparam int DCMI_DW      = 32;
  localparam int DCMI_DEPTH   = 16;

  // Packed entry layout: {sof, eof, data[DW-1:0]}
  localparam int DCMI_TAG_EOF = DCMI_DW;
  localparam int DCMI_TAG_SOF = DCMI_DW + 1;
  localparam int DCMI_ENTRY_W = DCMI_DW + 2;

endpackage

// File: rtl/dcmi_out_fifo_if.sv
// Output stream of the DCMI buffer towards the DMA/bus bridge.
//
// Handshake: a beat transfers at a rising clock edge where m_valid and
// m_ready are both 1. m_valid is registered and never depends on m_ready;
// once raised it stays up with stable data/tags until the beat transfers
// (or until reset/flush). m_data/m_sof/m_eof are zero whenever m_valid is 0.
interface dcmi_out_fifo_if #(
  parameter int DW = dcmi_out_fifo_pkg::DCMI_DW
) ();

  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_sof;
  logic          m_eof;

  modport master (
    output m_valid,
    output m_data,
    output m_sof,
    output m_eof,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_sof,
    input  m_eof,
    output m_ready
  );

endinterface

// File: rtl/dcmi_out_fifo_sync_fifo.sv
// Generic single-clock FIFO with occupancy count, non-empty flag and a
// drop indication for pushes that find the FIFO full with no pop that cycle.
module dcmi_sync_fifo
  import dcmi_out_fifo_pkg::*;
#(
  parameter int W     = DCMI_ENTRY_W,
  parameter int DEPTH = DCMI_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          valid_o,
  output logic [AW:0]   count_o,
  output logic          drop_o
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          valid_q, valid_d;
  logic          full;
  logic          pop_ok;
  logic          push_ok;

  assign full    = (count_q == FULL_CNT);
  assign pop_ok  = pop_i & valid_q;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign push_ok = push_i & (~full | pop_ok);
  assign drop_o  = push_i & full & ~pop_ok;

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = valid_q;
  assign count_o = count_q;

  // Next pointers, count and registered non-empty flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_ok && !pop_ok)      count_d = count_q + CNT_ONE;
    else if (!push_ok && pop_ok) count_d = count_q - CNT_ONE;
    valid_d = (count_d != '0);
  end

  // Pointer/count state; clr behaves exactly like reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Storage array write; contents need no reset since valid gates the head.
  always_ff @(posedge clk_i) begin
    if (rst_n && !clr_i && push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dcmi_out_fifo.sv
// DCMI output buffer: holds each captured word back by one word so the
// frame end can be tagged on the last word, then queues tagged words for
// the bus bridge. Input cannot be stalled, so full-FIFO pushes are dropped
// and reported as overruns.
module dcmi_out_fifo
  import dcmi_out_fifo_pkg::*;
#(
  parameter int DW    = DCMI_DW,
  parameter int DEPTH = DCMI_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  dcmi_pclk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  din_vld,
  input  logic [DW-1:0]         din,
  input  logic                  frame_start_pulse,
  input  logic                  frame_end_pulse,
  dcmi_out_fifo_if.master       m_if,
  output logic [AW:0]           level,
  output logic                  ovr_irq_pulse,
  output logic                  ovr_sticky
);

  localparam int EW      = DW + 2;
  localparam int TAG_EOF = DW;
  localparam int TAG_SOF = DW + 1;

  logic          stg_vld_q, stg_vld_d;
  logic [DW-1:0] stg_data_q, stg_data_d;
  logic          stg_sof_q, stg_sof_d;
  logic          sof_pend_q, sof_pend_d;
  logic          end_pend_q, end_pend_d;
  logic          ovr_irq_q;
  logic          ovr_sticky_q;

  logic          push;
  logic          push_eof;
  logic          sof_eff;
  logic [EW-1:0] push_entry;

  logic [EW-1:0] head_entry;
  logic          head_vld;
  logic          fifo_drop;

  // Staging/tagging decisions. At most one push per cycle; the frame-start
  // case wins over the normal word push and over the deferred frame end.
  always_comb begin
    stg_vld_d  = stg_vld_q;
    stg_data_d = stg_data_q;
    stg_sof_d  = stg_sof_q;
    sof_pend_d = sof_pend_q;
    end_pend_d = end_pend_q;
    push       = 1'b0;
    push_eof   = 1'b0;
    // A word arriving with the start pulse is the first of the new frame.
    sof_eff    = sof_pend_q | frame_start_pulse;

    if (frame_start_pulse && stg_vld_q) begin
      // Previous frame never saw its end: close it on the staged word.
      push       = 1'b1;
      push_eof   = 1'b1;
      stg_vld_d  = 1'b0;
      end_pend_d = 1'b0;
    end else if (din_vld && stg_vld_q) begin
      push       = 1'b1;
    end else if (end_pend_q && !din_vld) begin
      // First idle cycle after frame end: staged word is the last one.
      if (stg_vld_q) begin
        push      = 1'b1;
        push_eof  = 1'b1;
        stg_vld_d = 1'b0;
      end
      end_pend_d = 1'b0;
    end

    if (din_vld) begin
      stg_vld_d  = 1'b1;
      stg_data_d = din;
      stg_sof_d  = sof_eff;
      sof_pend_d = 1'b0;
    end else begin
      sof_pend_d = sof_eff;
    end

    if (frame_end_pulse) end_pend_d = 1'b1;
  end

  always_comb begin
    push_entry          = '0;
    push_entry[DW-1:0]  = stg_data_q;
    push_entry[TAG_EOF] = push_eof;
    push_entry[TAG_SOF] = stg_sof_q;
  end

  dcmi_sync_fifo #(
    .W     (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_i   (dcmi_pclk),
    .rst_n   (rst_n),
    .clr_i   (flush),
    .push_i  (push & ~flush),
    .wdata_i (push_entry),
    .pop_i   (m_if.m_ready),
    .rdata_o (head_entry),
    .valid_o (head_vld),
    .count_o (level),
    .drop_o  (fifo_drop)
  );

  // Staging, pending flags and overrun reporting.
  always_ff @(posedge dcmi_pclk) begin
    if (!rst_n || flush) begin
      stg_vld_q    <= 1'b0;
      stg_data_q   <= '0;
      stg_sof_q    <= 1'b0;
      sof_pend_q   <= 1'b0;
      end_pend_q   <= 1'b0;
      ovr_irq_q    <= 1'b0;
      ovr_sticky_q <= 1'b0;
    end else begin
      stg_vld_q    <= stg_vld_d;
      stg_data_q   <= stg_data_d;
      stg_sof_q    <= stg_sof_d;
      sof_pend_q   <= sof_pend_d;
      end_pend_q   <= end_pend_d;
      ovr_irq_q    <= fifo_drop;
      ovr_sticky_q <= ovr_sticky_q | fifo_drop;
    end
  end

  assign m_if.m_valid = head_vld;
  assign m_if.m_data  = head_vld ? head_entry[DW-1:0] : '0;
  assign m_if.m_sof   = head_vld & head_entry[TAG_SOF];
  assign m_if.m_eof   = head_vld & head_entry[TAG_EOF];

  assign ovr_irq_pulse = ovr_irq_q;
  assign ovr_sticky    = ovr_sticky_q;

endmodule

// File: tb/tb_dcmi_out_fifo.sv
// Directed plus randomized bench for dcmi_out_fifo. Expected beats are
// derived from frame structure (first word sof, last word eof) and queued
// in exp_q; a monitor compares every transferred beat against it.
module tb_dcmi_out_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  // ---------------- clock / reset ----------------
  logic dcmi_pclk = 1'b0;
  always #5 dcmi_pclk = ~dcmi_pclk;

  logic          rst_n;
  logic          flush;
  logic          din_vld;
  logic [DW-1:0] din;
  logic          frame_start_pulse;
  logic          frame_end_pulse;
  logic [AW:0]   level;
  logic          ovr_irq_pulse;
  logic          ovr_sticky;

  dcmi_out_fifo_if #(.DW(DW)) m_if ();

  dcmi_out_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .dcmi_pclk         (dcmi_pclk),
    .rst_n             (rst_n),
    .flush             (flush),
    .din_vld           (din_vld),
    .din               (din),
    .frame_start_pulse (frame_start_pulse),
    .frame_end_pulse   (frame_end_pulse),
    .m_if              (m_if),
    .level             (level),
    .ovr_irq_pulse     (ovr_irq_pulse),
    .ovr_sticky        (ovr_sticky)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int passed = 0;
  logic [DW+1:0] exp_q[$];   // {sof, eof, data}
  bit rand_rdy = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic exp_push(input logic sof, input logic eof, input logic [DW-1:0] d);
    exp_q.push_back({sof, eof, d});
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge dcmi_pclk);
    #1;
    if (rand_rdy) m_if.m_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic cyc(input logic vld, input logic [DW-1:0] d, input logic fs, input logic fe);
    din_vld           = vld;
    din               = d;
    frame_start_pulse = fs;
    frame_end_pulse   = fe;
    tick();
    din_vld           = 1'b0;
    frame_start_pulse = 1'b0;
    frame_end_pulse   = 1'b0;
  endtask

  task automatic word(input logic [DW-1:0] d);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic wait_room();
    int n;
    n = 0;
    while (level >= (AW+1)'(DEPTH - 3) && n < 300) begin
      idle(1);
      n++;
    end
    check("room_timeout", 64'(n < 300), 64'd1);
  endtask

  task automatic drain(input string tag);
    rand_rdy     = 1'b0;
    m_if.m_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (m_if.m_valid === 1'b0 && level === '0) break;
      idle(1);
    end
    check({tag, "_level"}, 64'(level), 64'd0);
    check({tag, "_valid"}, 64'(m_if.m_valid), 64'd0);
    check({tag, "_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"},  64'(m_if.m_valid), 64'd0);
    check({tag, "_level"},  64'(level), 64'd0);
    check({tag, "_irq"},    64'(ovr_irq_pulse), 64'd0);
    check({tag, "_sticky"}, 64'(ovr_sticky), 64'd0);
    check({tag, "_data"},   64'(m_if.m_data), 64'd0);
    check({tag, "_tags"},   64'({m_if.m_sof, m_if.m_eof}), 64'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge dcmi_pclk) begin
    if (rst_n === 1'b1 && flush === 1'b0 && m_if.m_valid === 1'b1 && m_if.m_ready === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) begin
        passed++;
        check("beat", 64'({m_if.m_sof, m_if.m_eof, m_if.m_data}), 64'(exp_q.pop_front()));
      end else $error("FAIL beat_extra: observed data 0x%0h sof %0d eof %0d expected no beat",
                      m_if.m_data, m_if.m_sof, m_if.m_eof);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] d;
    int pulses;
    int first_pulse;
    int len;
    bit skip_fep;

    rst_n = 1'b0; flush = 1'b0; din_vld = 1'b0; din = '0;
    frame_start_pulse = 1'b0; frame_end_pulse = 1'b0; m_if.m_ready = 1'b0;
    tick(); tick();
    check_zero("reset");
    rst_n = 1'b1;
    idle(1);

    // Basic frame, held back then drained.
    cyc(1'b0, '0, 1'b1, 1'b0);
    exp_push(1'b1, 1'b0, 32'h11); exp_push(1'b0, 1'b0, 32'h22);
    exp_push(1'b0, 1'b0, 32'h33); exp_push(1'b0, 1'b1, 32'h44);
    word(32'h11);
    check("basic_staged_valid", 64'(m_if.m_valid), 64'd0);
    word(32'h22);
    check("basic_head_valid", 64'(m_if.m_valid), 64'd1);
    check("basic_head_data",  64'(m_if.m_data), 64'h11);
    check("basic_head_tags",  64'({m_if.m_sof, m_if.m_eof}), 64'b10);
    check("basic_level1",     64'(level), 64'd1);
    word(32'h33); word(32'h44);
    cyc(1'b0, '0, 1'b0, 1'b1);
    check("basic_level3", 64'(level), 64'd3);
    idle(1);
    check("basic_level4", 64'(level), 64'd4);
    drain("basic");

    // Overrun: 20 words, FIFO never drained.
    m_if.m_ready = 1'b0;
    pulses = 0; first_pulse = 0;
    cyc(1'b0, '0, 1'b1, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      d = $urandom;
      if (i <= 16) exp_push(i == 1, 1'b0, d);
      word(d);
      check("ovr_pulse_word", 64'(ovr_irq_pulse), 64'(i >= 18));
      if (ovr_irq_pulse === 1'b1) begin
        pulses++;
        if (first_pulse == 0) first_pulse = i;
      end
    end
    cyc(1'b0, '0, 1'b0, 1'b1);
    check("ovr_pulse_fep", 64'(ovr_irq_pulse), 64'd0);
    idle(1);
    check("ovr_pulse_last", 64'(ovr_irq_pulse), 64'd1);
    if (ovr_irq_pulse === 1'b1) pulses++;
    idle(1);
    check("ovr_pulse_after", 64'(ovr_irq_pulse), 64'd0);
    check("ovr_pulses", 64'(pulses), 64'd4);
    check("ovr_first", 64'(first_pulse), 64'd18);
    check("ovr_level", 64'(level), 64'd16);
    check("ovr_sticky", 64'(ovr_sticky), 64'd1);
    drain("ovr");
    check("ovr_sticky_kept", 64'(ovr_sticky), 64'd1);
    flush = 1'b1; tick(); flush = 1'b0;
    check("ovr_flush_sticky", 64'(ovr_sticky), 64'd0);

    // Full FIFO with simultaneous pop and push.
    m_if.m_ready = 1'b0;
    cyc(1'b0, '0, 1'b1, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      d = $urandom;
      exp_push(i == 1, 1'b0, d);
      word(d);
    end
    check("full_level", 64'(level), 64'd16);
    d = $urandom;
    exp_push(1'b0, 1'b1, d);
    m_if.m_ready = 1'b1;
    word(d);
    check("full_pop_level", 64'(level), 64'd16);
    check("full_pop_irq", 64'(ovr_irq_pulse), 64'd0);
    check("full_pop_sticky", 64'(ovr_sticky), 64'd0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    idle(1);
    drain("full");

    // Missing frame end, new start arrives together with a word.
    m_if.m_ready = 1'b1;
    exp_push(1'b1, 1'b0, 32'hA0); exp_push(1'b0, 1'b1, 32'hB0);
    exp_push(1'b1, 1'b0, 32'hC0); exp_push(1'b0, 1'b1, 32'hD0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    word(32'hA0); word(32'hB0);
    cyc(1'b1, 32'hC0, 1'b1, 1'b0);
    word(32'hD0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    idle(2);
    drain("nofep");

    // Empty frame emits nothing; the start marker carries to the next word.
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("empty_valid", 64'(m_if.m_valid), 64'd0);
    end
    exp_push(1'b1, 1'b0, 32'h5A5A0001); exp_push(1'b0, 1'b1, 32'h5A5A0002);
    word(32'h5A5A0001); word(32'h5A5A0002);
    cyc(1'b0, '0, 1'b0, 1'b1);
    idle(1);
    drain("empty");

    // Reset mid-frame.
    m_if.m_ready = 1'b0;
    cyc(1'b0, '0, 1'b1, 1'b0);
    word(32'h1); word(32'h2); word(32'h3);
    check("rstmid_level", 64'(level), 64'd2);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_zero("rstmid");
    exp_q.delete();
    exp_push(1'b0, 1'b0, 32'h77); exp_push(1'b0, 1'b1, 32'h88);
    word(32'h77); word(32'h88);
    cyc(1'b0, '0, 1'b0, 1'b1);
    idle(1);
    drain("rstmid");

    // Flush mid-frame after an overrun.
    m_if.m_ready = 1'b0;
    cyc(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) word($urandom);
    check("flush_pre_sticky", 64'(ovr_sticky), 64'd1);
    flush = 1'b1; tick(); flush = 1'b0;
    check_zero("flush");
    exp_q.delete();
    exp_push(1'b0, 1'b0, 32'h99); exp_push(1'b0, 1'b1, 32'hAA);
    word(32'h99); word(32'hAA);
    cyc(1'b0, '0, 1'b0, 1'b1);
    idle(1);
    drain("flush");

    // Randomized frames with random gaps, random ready and dropped frame ends.
    rand_rdy = 1'b1;
    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(0, 6);
      skip_fep = ($urandom_range(0, 4) == 0) && (f != 29) && (len > 0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      for (int k = 0; k < len; k++) begin
        wait_room();
        if ($urandom_range(0, 2) == 0) idle(1);
        d = $urandom;
        exp_push(k == 0, k == len - 1, d);
        word(d);
      end
      if (!skip_fep) begin
        cyc(1'b0, '0, 1'b0, 1'b1);
        idle($urandom_range(1, 3));
      end
    end
    drain("rand");
    check("rand_sticky", 64'(ovr_sticky), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
